// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: read-side drainer for the synchronous FIFO.
// Issues fifo_rd_en, captures the FIFO's registered data_out one clock later
// into a 3-entry skid buffer, and presents words in order on a valid/ready stream.
// Also keeps a sticky underflow flag and counts delivered words.
//
// Stream handshake: a word transfers on any rising edge where m_valid and
// m_ready are both high. Once m_valid is raised it stays high, and m_data
// stays stable, until that transfer happens. m_ready may toggle freely.
// m_valid does not depend on m_ready, and fifo_rd_en depends only on
// registers and the FIFO flags. There is no combinational path from m_ready
// to fifo_rd_en.
module fifo_rd_stream #(
  parameter int FIFO_WIDTH = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  output logic                  fifo_rd_en,
  input  logic [FIFO_WIDTH-1:0] fifo_data_out,
  input  logic                  fifo_empty,
  input  logic                  fifo_underflow,
  output logic                  m_valid,
  output logic [FIFO_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  rd_count,
  output logic                  underflow_err,
  input  logic                  clr_err,
  output logic [1:0]            state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

  state_t                  state;
  state_t                  state_nxt;

  // Skid buffer storage and bookkeeping.
  logic [FIFO_WIDTH-1:0]   mem [0:2];
  logic [1:0]              rd_ptr;
  logic [1:0]              wr_ptr;
  logic [1:0]              occ;
  logic                    inflight;

  logic                    push;
  logic                    pop;
  logic [2:0]              pending;

  // Advance a buffer pointer, wrapping 2 -> 0.
  function automatic logic [1:0] next_ptr(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Words already committed to the buffer: those stored plus the one in flight.
  assign pending = {1'b0, occ} + {2'b00, inflight};

  // Only issue a read when a buffer slot is guaranteed for the returning word.
  assign fifo_rd_en = (state == RUN) & ~fifo_empty & (pending < 3'd3);

  // The FIFO data returned for last cycle's read is written now; a pop happens on handshake.
  assign push = inflight;
  assign pop  = m_valid & m_ready;

  // Stream outputs come straight from the buffer head.
  assign m_valid   = (occ != 2'd0);
  assign m_data    = (occ != 2'd0) ? mem[rd_ptr] : '0;
  assign busy      = (state != IDLE);
  assign state_dbg = state;

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state: STOP keeps delivering until nothing is buffered or in flight.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (en) state_nxt = RUN;
      end
      RUN: begin
        if (!en) state_nxt = STOP;
      end
      STOP: begin
        if (en) begin
          state_nxt = RUN;
        end else if ((occ == 2'd0) && !inflight) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Track the read issued last cycle so its data is captured on this edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight <= 1'b0;
    end else begin
      inflight <= fifo_rd_en;
    end
  end

  // Skid buffer entries: the returning word goes into the tail slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        mem[i] <= '0;
      end
    end else if (push) begin
      mem[wr_ptr] <= fifo_data_out;
    end
  end

  // Skid buffer pointers and occupancy; simultaneous push and pop leave occ unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= 2'd0;
      wr_ptr <= 2'd0;
      occ    <= 2'd0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  // Delivered-word counter, wraps naturally at its width.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_count <= '0;
    end else if (pop) begin
      rd_count <= rd_count + CNT_WIDTH'(1);
    end
  end

  // Sticky underflow flag; a new underflow wins over a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      underflow_err <= 1'b0;
    end else if (fifo_underflow) begin
      underflow_err <= 1'b1;
    end else if (clr_err) begin
      underflow_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: a queue-based FIFO model feeds the DUT, and a
// scoreboard predicts read strobes, stream words, latency, counters and flags.
module tb_fifo_rd_stream;

  localparam int W  = 16;
  localparam int CW = 16;

  // ---------------- clock / reset block ----------------
  logic          clk = 1'b0;
  logic          rst = 1'b0;
  always #5 clk = ~clk;

  logic          en = 1'b0;
  logic          fifo_rd_en;
  logic [W-1:0]  fifo_data_out = '0;
  logic          fifo_empty = 1'b1;
  logic          fifo_underflow = 1'b0;
  logic          m_valid;
  logic [W-1:0]  m_data;
  logic          m_ready = 1'b0;
  logic          busy;
  logic [CW-1:0] rd_count;
  logic          underflow_err;
  logic          clr_err = 1'b0;
  logic [1:0]    state_dbg;

  fifo_rd_stream #(.FIFO_WIDTH(W), .CNT_WIDTH(CW)) dut (
    .clk            (clk),
    .rst            (rst),
    .en             (en),
    .fifo_rd_en     (fifo_rd_en),
    .fifo_data_out  (fifo_data_out),
    .fifo_empty     (fifo_empty),
    .fifo_underflow (fifo_underflow),
    .m_valid        (m_valid),
    .m_data         (m_data),
    .m_ready        (m_ready),
    .busy           (busy),
    .rd_count       (rd_count),
    .underflow_err  (underflow_err),
    .clr_err        (clr_err),
    .state_dbg      (state_dbg)
  );

  // ---------------- scoreboard / model state ----------------
  int            checks   = 0;
  int            failures = 0;

  logic [W-1:0]  fifo_q[$];   // words still held in the FIFO
  logic [W-1:0]  exp_q[$];    // words read but not yet delivered, in order
  int            avail_q[$];  // cycle at which each exp_q word may appear
  int            cyc = 0;
  int            issued = 0;
  int            delivered = 0;
  logic [CW-1:0] cnt_m = '0;
  logic          uf_m = 1'b0;
  logic          busy_m = 1'b0;
  logic          en_d1 = 1'b0;
  logic          rd_pend = 1'b0;
  logic [W-1:0]  rd_word = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic load_fifo(input int first, input int n);
    fifo_q.delete();
    for (int i = 0; i < n; i++) fifo_q.push_back(W'(first + i));
  endtask

  // Reset with the FIFO non-empty and en high; outputs must drop immediately.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    en = 1'b1;
    fifo_empty = 1'b0;
    m_ready = 1'b0;
    fifo_underflow = 1'b0;
    clr_err = 1'b0;
    #1;
    chk("rst_rd_en", fifo_rd_en, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_rd_count", rd_count, 0);
    chk("rst_uf_err", underflow_err, 0);
    chk("rst_busy", busy, 0);
    exp_q.delete();
    avail_q.delete();
    issued = 0;
    delivered = 0;
    cnt_m = '0;
    uf_m = 1'b0;
    busy_m = 1'b0;
    en_d1 = 1'b0;
    rd_pend = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    en = 1'b0;
    fifo_empty = (fifo_q.size() == 0);
    cyc++;
  endtask

  // One clock cycle: drive inputs at negedge, check predictions, advance model.
  task automatic step(input logic s_en, input logic s_rdy, input logic s_uf, input logic s_clr);
    int   outstanding;
    logic exp_rd;
    logic exp_valid;
    @(negedge clk);
    en = s_en;
    m_ready = s_rdy;
    fifo_underflow = s_uf;
    clr_err = s_clr;
    fifo_empty = (fifo_q.size() == 0);
    if (rd_pend) fifo_data_out = rd_word;
    rd_pend = 1'b0;
    #1;
    outstanding = issued - delivered;
    exp_rd    = en_d1 && !fifo_empty && (outstanding < 3);
    exp_valid = (exp_q.size() > 0) && (avail_q[0] <= cyc);
    chk("rd_en", fifo_rd_en, exp_rd);
    chk("m_valid", m_valid, exp_valid);
    if (exp_valid) chk("m_data", m_data, exp_q[0]);
    else           chk("m_data_idle", m_data, 0);
    chk("rd_count", rd_count, cnt_m);
    chk("busy", busy, busy_m);
    chk("uf_err", underflow_err, uf_m);
    // FIFO model answers the DUT's actual strobe.
    if (fifo_rd_en && !fifo_empty) begin
      rd_word = fifo_q.pop_front();
      rd_pend = 1'b1;
      exp_q.push_back(rd_word);
      avail_q.push_back(cyc + 2);
      issued++;
    end
    if (exp_valid && s_rdy) begin
      void'(exp_q.pop_front());
      void'(avail_q.pop_front());
      delivered++;
      cnt_m = cnt_m + CW'(1);
    end
    if (s_uf)       uf_m = 1'b1;
    else if (s_clr) uf_m = 1'b0;
    // Active unless the stop phase has just run dry.
    busy_m = s_en | (busy_m & (en_d1 | (outstanding != 0)));
    en_d1 = s_en;
    cyc++;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // T1: reset with work available and en high
    load_fifo(1, 8);
    do_reset();

    // T2: full-rate drain of 1..8
    for (int i = 0; i < 16; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("t2_reads", issued, 8);
    chk("t2_count", rd_count, 8);

    // T3: stalled sink, then release
    load_fifo(1, 8);
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("t3_reads", issued, 3);
    chk("t3_head", m_data, 16'h0001);
    for (int i = 0; i < 16; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("t3_count", rd_count, 8);

    // T4: en drops in the cycle of the 4th read
    load_fifo(1, 8);
    do_reset();
    for (int i = 0; i < 14; i++) step(issued < 3, 1'b1, 1'b0, 1'b0);
    chk("t4_reads", issued, 4);
    chk("t4_count", rd_count, 4);
    chk("t4_busy", busy, 0);

    // T5: sticky underflow and clear priority
    step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("t5_hold", underflow_err, 1);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("t5_clear", underflow_err, 0);

    // T6: reset with two words buffered, then resume from the next FIFO word
    load_fifo(1, 8);
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("t6_resume", m_data, 16'h0004);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    chk("t6_count", rd_count, 5);

    // Randomized traffic: refills, en toggles, backpressure, flag pulses
    fifo_q.delete();
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) != 0 && fifo_q.size() < 16)
        fifo_q.push_back(W'($urandom_range(0, 65535)));
      step($urandom_range(0, 9) != 0,
           $urandom_range(0, 2) != 0,
           $urandom_range(0, 29) == 0,
           $urandom_range(0, 19) == 0);
    end
    // Drain what remains
    for (int i = 0; i < 60; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("rand_drained", exp_q.size(), 0);

    // ---------------- final report ----------------
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
